universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits.
REQ-002 The block SHALL have parameter LANES, default 1, giving the serial lane count, which is also the bits moved per shift; WIDTH SHALL be a multiple of LANES.
REQ-003 The block SHALL have derived constant NSH = WIDTH/LANES (shifts per frame) and CW = $clog2(NSH+1).
REQ-004 Port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port en  input  1  operation enable; when 0, all state SHALL hold and done SHALL be 0 next cycle.
REQ-007 Port mode  input  3  operation select (see REQ-011).
REQ-008 Ports srl_in_l  input  LANES  serial data entering at the LSB end on shift-left; srl_in_r  input  LANES  serial data entering at the MSB end on shift-right.
REQ-009 Ports prl_in  input  WIDTH  parallel load data; prl_out  output  WIDTH  register contents; srl_out_l  output  LANES  equal to prl_out[WIDTH-1 -: LANES]; srl_out_r  output  LANES  equal to prl_out[LANES-1:0].
REQ-010 Ports shift_cnt  output  CW  shifts since the last load/clear/frame end; done  output  1  frame-complete pulse.

Function
REQ-011 With en=1, mode SHALL select the operation:
- 0: hold
- 1: shift left, q <= {q[WIDTH-LANES-1:0], srl_in_l}
- 2: shift right, q <= {srl_in_r, q[WIDTH-1:LANES]}
- 3: rotate left by LANES
- 4: rotate right by LANES
- 5: parallel load, q <= prl_in
- 6: clear, q <= 0
- 7: hold
REQ-012 prl_out, srl_out_l and srl_out_r SHALL be driven combinationally from the register, with no added latency.
REQ-013 An operation SHALL become visible on prl_out one cycle after the edge on which it is sampled.
REQ-014 Modes 1-4 (shift class) SHALL increment shift_cnt by 1.
REQ-015 When a shift-class operation occurs with shift_cnt == NSH-1, shift_cnt SHALL wrap to 0 and done SHALL be 1 for exactly the next cycle.
REQ-016 Modes 5 and 6 SHALL set shift_cnt to 0 and SHALL NOT assert done, regardless of the prior count.
REQ-017 Modes 0 and 7, and en=0, SHALL leave q and shift_cnt unchanged and drive done to 0.
REQ-018 done SHALL be a registered output and SHALL never stay high for two consecutive cycles unless a further frame completes; with NSH=1, every shift completes a frame.
REQ-019 Left and right shifts SHALL share one counter: mixing directions within a frame is legal and counts every shift.
REQ-020 mode SHALL be sampled only when en=1; values of serial and parallel inputs in unused modes SHALL have no effect.
REQ-021 The block SHALL have no backpressure, so every enabled operation completes in one cycle.

Reset
REQ-022 While rst=1, the block SHALL force q=0, shift_cnt=0 and done=0 immediately, independent of clk.
REQ-023 Reset asserted mid-frame SHALL discard the partial count, and no done SHALL follow from it.
REQ-024 After rst deasserts, the first rising edge SHALL perform the sampled operation normally.

Verification (WIDTH=8, LANES=1 unless stated)
REQ-025 Load then shift: load 0xA5, then 8x mode 1 with srl_in_l=1. Required: prl_out follows 0x4B, 0x97, ..., 0xFF; srl_out_l before each shift follows 1,0,1,0,0,1,0,1; done high exactly in the cycle after the 8th shift; shift_cnt back at 0.
REQ-026 Rotate: load 0x81, then mode 4 once. Required: prl_out=0xC0. Then 8x mode 3. Required: prl_out=0xC0 and one done pulse.
REQ-027 Interrupted frame: load 0x00, 5x mode 2 with srl_in_r=1, then mode 5 with 0x3C. Required: after the shifts prl_out=0xF8; after the load prl_out=0x3C, shift_cnt=0, no done.
REQ-028 Enable/hold: 3 shifts, 4 cycles of en=0 with mode=1, then 5 shifts. Required: shift_cnt=3 throughout the stall; done after the 8th enabled shift only.
REQ-029 Async reset: assert rst between edges after 6 shifts. Required: prl_out=0 and shift_cnt=0 before the next edge; no done; then 8 shifts produce exactly one done.
REQ-030 Multi-lane (WIDTH=8, LANES=2): load 0x1B, 4x mode 1 with srl_in_l=2'b10. Required: prl_out=0xAA; done after the 4th shift; srl_out_r=2'b10.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: load, clear, shift and rotate by LANES bits,
// with a shared shift counter that pulses done when a frame completes.
module universal_shift_reg #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned LANES = 1,
    localparam int unsigned NSH   = WIDTH / LANES,
    localparam int unsigned CW    = $clog2(NSH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [LANES-1:0] srl_in_l,
    input  logic [LANES-1:0] srl_in_r,
    input  logic [WIDTH-1:0] prl_in,
    output logic [WIDTH-1:0] prl_out,
    output logic [LANES-1:0] srl_out_l,
    output logic [LANES-1:0] srl_out_r,
    output logic [CW-1:0]    shift_cnt,
    output logic             done
);

    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_ROL  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_LOAD = 3'd5;
    localparam logic [2:0] MODE_CLR  = 3'd6;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             done_nxt;
    logic             is_shift;

    // Next register value, counter and frame-complete pulse for this cycle
    always_comb begin
        q_nxt    = q;
        cnt_nxt  = shift_cnt;
        done_nxt = 1'b0;
        is_shift = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHL: begin
                    q_nxt    = (q << LANES) | WIDTH'(srl_in_l);
                    is_shift = 1'b1;
                end
                MODE_SHR: begin
                    q_nxt    = (q >> LANES) | (WIDTH'(srl_in_r) << (WIDTH - LANES));
                    is_shift = 1'b1;
                end
                MODE_ROL: begin
                    q_nxt    = (q << LANES) | (q >> (WIDTH - LANES));
                    is_shift = 1'b1;
                end
                MODE_ROR: begin
                    q_nxt    = (q >> LANES) | (q << (WIDTH - LANES));
                    is_shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_nxt   = prl_in;
                    cnt_nxt = '0;
                end
                MODE_CLR: begin
                    q_nxt   = '0;
                    cnt_nxt = '0;
                end
                default: begin
                    q_nxt = q;
                end
            endcase
            // Left and right moves share one counter; last shift of a frame wraps it
            if (is_shift) begin
                if (shift_cnt == CW'(NSH - 1)) begin
                    cnt_nxt  = '0;
                    done_nxt = 1'b1;
                end else begin
                    cnt_nxt = shift_cnt + CW'(1);
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q         <= '0;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else begin
            q         <= q_nxt;
            shift_cnt <= cnt_nxt;
            done      <= done_nxt;
        end
    end

    // Register contents exposed directly, no added latency
    assign prl_out   = q;
    assign srl_out_l = q[WIDTH-1 -: LANES];
    assign srl_out_r = q[LANES-1:0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed sequences plus random traffic,
// checked every cycle against an arithmetic model of register and frame count.
`timescale 1ns/1ps
module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [2:0] mode = 3'd0;
    logic       sl1 = 1'b0, sr1 = 1'b0;
    logic [1:0] sl2 = 2'd0, sr2 = 2'd0;
    logic [7:0] prl_in = 8'd0;

    logic [7:0] out1, out2;
    logic       ol1, or1;
    logic [1:0] ol2, or2;
    logic [3:0] cnt1;
    logic [2:0] cnt2;
    logic       done1, done2;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    // Reference state: register value, shifts into current frame, done pulse
    int unsigned m1_q = 0, m1_cnt = 0, m2_q = 0, m2_cnt = 0;
    bit          m1_done = 0, m2_done = 0;

    universal_shift_reg #(.WIDTH(8), .LANES(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .srl_in_l(sl1), .srl_in_r(sr1), .prl_in(prl_in),
        .prl_out(out1), .srl_out_l(ol1), .srl_out_r(or1),
        .shift_cnt(cnt1), .done(done1)
    );

    universal_shift_reg #(.WIDTH(8), .LANES(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .srl_in_l(sl2), .srl_in_r(sr2), .prl_in(prl_in),
        .prl_out(out2), .srl_out_l(ol2), .srl_out_r(or2),
        .shift_cnt(cnt2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One enabled operation on a w-bit register moved l bits per shift
    task automatic model_step(input int unsigned w, input int unsigned l, input int unsigned m,
                              input int unsigned sl, input int unsigned sr, input int unsigned pl,
                              inout int unsigned q, inout int unsigned cnt, output bit dn);
        int unsigned full, step, nsh;
        full = 1 << w;
        step = 1 << l;
        nsh  = w / l;
        dn   = 0;
        case (m)
            1: q = (q * step + sl) % full;
            2: q = q / step + sr * (1 << (w - l));
            3: q = (q * step) % full + q / (1 << (w - l));
            4: q = q / step + (q % step) * (1 << (w - l));
            5: q = pl;
            6: q = 0;
            default: ;
        endcase
        if (m >= 1 && m <= 4) begin
            cnt = (cnt + 1) % nsh;
            dn  = (cnt == 0);
        end else if (m == 5 || m == 6) begin
            cnt = 0;
        end
    endtask

    // Reference model advances on the same edges as the DUT
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_q = 0; m1_cnt = 0; m1_done = 0;
            m2_q = 0; m2_cnt = 0; m2_done = 0;
        end else begin
            m1_done = 0;
            m2_done = 0;
            if (en) begin
                model_step(8, 1, mode, sl1, sr1, prl_in, m1_q, m1_cnt, m1_done);
                model_step(8, 2, mode, sl2, sr2, prl_in, m2_q, m2_cnt, m2_done);
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            check("l1_prl_out",   out1,  m1_q);
            check("l1_srl_out_l", ol1,   m1_q / 128);
            check("l1_srl_out_r", or1,   m1_q % 2);
            check("l1_shift_cnt", cnt1,  m1_cnt);
            check("l1_done",      done1, m1_done);
            check("l2_prl_out",   out2,  m2_q);
            check("l2_srl_out_l", ol2,   m2_q / 64);
            check("l2_srl_out_r", or2,   m2_q % 4);
            check("l2_shift_cnt", cnt2,  m2_cnt);
            check("l2_done",      done2, m2_done);
        end
    end

    // Drive one operation (called at a falling edge) and return at the next falling edge
    task automatic step(input logic e, input logic [2:0] m, input logic [1:0] l, input logic [1:0] r,
                        input logic [7:0] p);
        en     = e;
        mode   = m;
        sl1    = l[0];
        sr1    = r[0];
        sl2    = l;
        sr2    = r;
        prl_in = p;
        @(negedge clk);
    endtask

    // Reset pulse placed between a falling and the next rising edge
    task automatic async_reset();
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("areset_prl_out", out1, 8'h00);
        check("areset_cnt",     cnt1, 4'd0);
        check("areset_done",    done1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] seq_a5 [8];
    logic       msb_a5 [8];

    initial begin
        seq_a5 = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
        msb_a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        @(negedge clk);
        check("reset_prl_out", out1, 8'h00);
        check("reset_cnt",     cnt1, 4'd0);
        check("reset_done",    done1, 1'b0);
        rst = 1'b0;
        cmp_on = 1'b1;

        // Load then shift left eight times with 1 entering
        step(1, 3'd5, 2'b00, 2'b00, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            check("a5_msb_before", ol1, msb_a5[i]);
            step(1, 3'd1, 2'b01, 2'b00, 8'h00);
            check("a5_prl_out", out1, seq_a5[i]);
            check("a5_done", done1, (i == 7));
        end
        check("a5_cnt_end", cnt1, 4'd0);

        // Rotate right once, then a full rotate-left frame
        step(1, 3'd5, 2'b00, 2'b00, 8'h81);
        step(1, 3'd4, 2'b00, 2'b00, 8'h00);
        check("ror_prl_out", out1, 8'hC0);
        for (int i = 0; i < 8; i++) begin
            step(1, 3'd3, 2'b00, 2'b00, 8'h00);
            check("rol_done", done1, (i == 6));
        end
        check("rol_prl_out", out1, 8'hC0);

        // Interrupted frame: partial right shifts then a reload
        step(1, 3'd5, 2'b00, 2'b00, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 3'd2, 2'b00, 2'b01, 8'h00);
        check("intr_shr_prl_out", out1, 8'hF8);
        step(1, 3'd5, 2'b00, 2'b00, 8'h3C);
        check("intr_load_prl_out", out1, 8'h3C);
        check("intr_load_cnt",     cnt1, 4'd0);
        check("intr_load_done",    done1, 1'b0);

        // Stall with en low mid-frame
        for (int i = 0; i < 3; i++) step(1, 3'd1, 2'b00, 2'b00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(0, 3'd1, 2'b01, 2'b01, 8'hFF);
            check("stall_cnt",  cnt1, 4'd3);
            check("stall_done", done1, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 3'd1, 2'b00, 2'b00, 8'h00);
            check("stall_resume_done", done1, (i == 4));
        end

        // Asynchronous reset after six shifts
        step(1, 3'd6, 2'b00, 2'b00, 8'h00);
        for (int i = 0; i < 6; i++) step(1, 3'd1, 2'b01, 2'b00, 8'h00);
        async_reset();
        check("post_reset_done", done1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1, 3'd2, 2'b00, 2'b01, 8'h00);
            check("post_reset_shift_done", done1, (i == 7));
        end

        // Two-lane frame: load 0x1B then four left shifts of 2'b10
        step(1, 3'd5, 2'b00, 2'b00, 8'h1B);
        for (int i = 0; i < 4; i++) begin
            step(1, 3'd1, 2'b10, 2'b00, 8'h00);
            check("lane2_done", done2, (i == 3));
        end
        check("lane2_prl_out",   out2, 8'hAA);
        check("lane2_srl_out_r", or2,  2'b10);

        // Random traffic biased toward shifts, with occasional async resets
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] m;
            m = ($urandom % 4 == 0) ? 3'($urandom % 8) : 3'(1 + $urandom % 4);
            if ($urandom % 200 == 0) async_reset();
            step(($urandom % 8) != 0, m, 2'($urandom), 2'($urandom), 8'($urandom));
        end

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
